// File: rtl/dna_access_arbiter_pkg.sv
// Shared types and sizes for the DNA access arbiter slice.
package atomik_dna_pkg;

  localparam int unsigned WORDS  = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned REQ_N  = 2;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOCK  = 2'd1,
    S_SERVE = 2'd2
  } state_e;

endpackage

// File: rtl/dna_access_arbiter_if.sv
// Loader-side inputs plus the two-requester read port of the DNA arbiter.
interface dna_access_arbiter_if;
  import atomik_dna_pkg::*;

  logic [WORDS*WORD_W-1:0] dna_storage;
  logic                    otp_en;
  logic                    core_enable;
  logic                    loader_busy;
  logic [REQ_N-1:0]        req_valid;
  logic [IDX_W-1:0]        req_idx0;
  logic [IDX_W-1:0]        req_idx1;
  logic [REQ_N-1:0]        req_ready;
  logic                    rsp_valid;
  logic                    rsp_id;
  logic [WORD_W-1:0]       rsp_data;
  logic                    rsp_burned;
  logic [CNT_W-1:0]        words_left;
  logic                    pad_exhausted;

  modport slave (
    input  dna_storage, otp_en, core_enable, loader_busy, req_valid, req_idx0, req_idx1,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_burned, words_left, pad_exhausted
  );

  modport master (
    output dna_storage, otp_en, core_enable, loader_busy, req_valid, req_idx0, req_idx1,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_burned, words_left, pad_exhausted
  );

endinterface

// File: rtl/dna_access_arbiter_rr.sv
// Two-way round-robin arbiter; the pointer remembers the last accepted requester.
module rr_arbiter2
  import atomik_dna_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [REQ_N-1:0] valid_i,
  output logic [REQ_N-1:0] gnt_c_o
);

  logic last_q, last_d;

  // Reset as if requester 1 won last, so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_DBG;
    else        last_q <= last_d;
  end

  always_comb begin
    gnt_c_o = '0;
    last_d  = last_q;
    if (en_i) begin
      unique case (valid_i)
        2'b01:   gnt_c_o = 2'b01;
        2'b10:   gnt_c_o = 2'b10;
        2'b11:   gnt_c_o = (last_q == REQ_CORE) ? 2'b10 : 2'b01;
        default: gnt_c_o = 2'b00;
      endcase
    end
    if (|gnt_c_o) last_d = gnt_c_o[1];
  end

endmodule

// File: rtl/dna_access_arbiter.sv
// Captures the committed DNA image and serves word reads to two requesters,
// with optional burn-on-read and lockout while the loader is active.
module dna_access_arbiter
  import atomik_dna_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  dna_access_arbiter_if.slave bus
);

  state_e                       state_q, state_d;
  logic [WORDS-1:0][WORD_W-1:0] mirror_q, mirror_d;
  logic [WORDS-1:0]             mask_q, mask_d;
  logic                         otp_q, otp_d;
  logic [CNT_W-1:0]             left_q, left_d;
  logic                         pad_q, pad_d;
  logic                         core_en_q;
  logic                         rsp_valid_q, rsp_valid_d;
  logic                         rsp_id_q, rsp_id_d;
  logic [WORD_W-1:0]            rsp_data_q, rsp_data_d;
  logic                         rsp_burned_q, rsp_burned_d;

  logic                         rise_c;
  logic                         arb_en_c;
  logic [REQ_N-1:0]             gnt_c;
  logic [IDX_W-1:0]             idx_c;

  assign rise_c   = bus.core_enable & ~core_en_q;
  // No grants while the mirror is being cleared or reloaded this cycle.
  assign arb_en_c = (state_q == S_SERVE) & ~bus.loader_busy & ~rise_c;
  assign idx_c    = gnt_c[1] ? bus.req_idx1 : bus.req_idx0;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (arb_en_c),
    .valid_i (bus.req_valid),
    .gnt_c_o (gnt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      mirror_q     <= '0;
      mask_q       <= '1;
      otp_q        <= 1'b0;
      left_q       <= '0;
      pad_q        <= 1'b0;
      core_en_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_burned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mirror_q     <= mirror_d;
      mask_q       <= mask_d;
      otp_q        <= otp_d;
      left_q       <= left_d;
      pad_q        <= pad_d;
      core_en_q    <= bus.core_enable;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_burned_q <= rsp_burned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mirror_d     = mirror_q;
    mask_d       = mask_q;
    otp_d        = otp_q;
    left_d       = left_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_burned_d = rsp_burned_q;

    if (bus.loader_busy) begin
      state_d  = S_LOCK;
      mirror_d = '0;
      mask_d   = '1;
      left_d   = '0;
    end else if (rise_c) begin
      state_d  = S_SERVE;
      mirror_d = bus.dna_storage;
      otp_d    = bus.otp_en;
      mask_d   = '0;
      left_d   = CNT_W'(WORDS);
    end else begin
      if (state_q == S_LOCK) state_d = S_EMPTY;
      if (|gnt_c) begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = gnt_c[1];
        rsp_data_d   = mask_q[idx_c] ? '0 : mirror_q[idx_c];
        rsp_burned_d = mask_q[idx_c];
        // First read of a word under burn-on-read destroys it.
        if (otp_q && !mask_q[idx_c]) begin
          mask_d[idx_c]   = 1'b1;
          mirror_d[idx_c] = '0;
          if (left_q != '0) left_d = left_q - CNT_W'(1);
        end
      end
    end

    pad_d = otp_d && (left_d == '0);
  end

  assign bus.req_ready     = gnt_c;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_burned    = rsp_burned_q;
  assign bus.words_left    = left_q;
  assign bus.pad_exhausted = pad_q;

endmodule

// File: tb/tb_dna_access_arbiter.sv
// Directed bench for dna_access_arbiter with a response scoreboard and monitor.
module tb_dna_access_arbiter;
  import atomik_dna_pkg::*;

  logic clk;
  logic rst_n;
  dna_access_arbiter_if bus ();

  dna_access_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        burned;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc_n  = 0;
  logic [31:0] mimg[8];
  bit   [7:0]  mburn;
  bit          motp;
  logic [255:0] img;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest expectation, one cycle after its grant.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id",      32'(bus.rsp_id),     32'(e.id));
        chk("rsp_data",    bus.rsp_data,        e.data);
        chk("rsp_burned",  32'(bus.rsp_burned), 32'(e.burned));
        chk("rsp_latency", 32'(cyc_n - e.cyc),  32'd1);
      end
    end
  end

  task automatic push(input int r, input logic [2:0] k);
    exp_t e;
    e.id     = r[0];
    e.burned = mburn[k];
    e.data   = mburn[k] ? 32'h0 : mimg[k];
    e.cyc    = cyc_n;
    sb.push_back(e);
    if (motp && !mburn[k]) mburn[k] = 1'b1;
  endtask

  // One request cycle: drive, check the grant mid-cycle, record expected response.
  task automatic cyc(input logic [1:0] v, input logic [2:0] i0, input logic [2:0] i1,
                     input logic [1:0] eg, input string nm);
    bus.req_valid = v;
    bus.req_idx0  = i0;
    bus.req_idx1  = i1;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(bus.req_ready), 32'(eg));
    for (int r = 0; r < 2; r++)
      if (bus.req_ready[r] === 1'b1) push(r, (r == 1) ? i1 : i0);
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic idle_chk(input string nm, input logic [3:0] left, input logic pad);
    @(negedge clk);
    chk({nm, "_left"}, 32'(bus.words_left),    32'(left));
    chk({nm, "_pad"},  32'(bus.pad_exhausted), 32'(pad));
    @(posedge clk); #1;
  endtask

  task automatic load(input bit o, input string nm);
    bus.req_valid   = 2'b11;
    bus.req_idx0    = 3'd0;
    bus.req_idx1    = 3'd0;
    bus.loader_busy = 1'b1;
    bus.core_enable = 1'b0;
    @(negedge clk);
    chk({nm, "_busy_rdy"}, 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.loader_busy = 1'b0;
    bus.core_enable = 1'b1;
    bus.dna_storage = img;
    bus.otp_en      = o;
    @(negedge clk);
    chk({nm, "_cap_rdy"}, 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    mburn = '0;
    motp  = o;
    idle_chk(nm, 4'd8, 1'b0);
  endtask

  task automatic chk_reset(input string nm);
    @(negedge clk);
    chk({nm, "_ready"},  32'(bus.req_ready),     32'd0);
    chk({nm, "_valid"},  32'(bus.rsp_valid),     32'd0);
    chk({nm, "_id"},     32'(bus.rsp_id),        32'd0);
    chk({nm, "_data"},   bus.rsp_data,           32'd0);
    chk({nm, "_burned"}, 32'(bus.rsp_burned),    32'd0);
    chk({nm, "_left"},   32'(bus.words_left),    32'd0);
    chk({nm, "_pad"},    32'(bus.pad_exhausted), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      mimg[k]          = 32'h11111111 * 32'(k);
      img[32*k +: 32]  = mimg[k];
    end
    mburn           = '1;
    motp            = 1'b0;
    bus.dna_storage = '0;
    bus.otp_en      = 1'b0;
    bus.core_enable = 1'b0;
    bus.loader_busy = 1'b0;
    bus.req_valid   = '0;
    bus.req_idx0    = '0;
    bus.req_idx1    = '0;
    rst_n           = 1'b1;
    #1 rst_n = 1'b0;
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain load, single read.
    load(1'b0, "load_plain");
    cyc(2'b01, 3'd3, 3'd0, 2'b01, "plain_rd3");
    idle_chk("plain_after", 4'd8, 1'b0);

    // Burn-on-read: second read of the same word is zero/burned.
    load(1'b1, "load_otp");
    cyc(2'b01, 3'd5, 3'd0, 2'b01, "otp_rd5a");
    cyc(2'b01, 3'd5, 3'd0, 2'b01, "otp_rd5b");
    idle_chk("otp_after", 4'd7, 1'b0);

    // Both requesters continuously valid; requester 0 won last, so 1 goes first.
    cyc(2'b11, 3'd0, 3'd1, 2'b10, "rr0");
    cyc(2'b11, 3'd0, 3'd1, 2'b01, "rr1");
    cyc(2'b11, 3'd0, 3'd1, 2'b10, "rr2");
    cyc(2'b11, 3'd0, 3'd1, 2'b01, "rr3");
    idle_chk("rr_after", 4'd5, 1'b0);

    // Drain the pad.
    cyc(2'b10, 3'd0, 3'd2, 2'b10, "drain2");
    cyc(2'b10, 3'd0, 3'd3, 2'b10, "drain3");
    cyc(2'b10, 3'd0, 3'd4, 2'b10, "drain4");
    cyc(2'b10, 3'd0, 3'd6, 2'b10, "drain6");
    idle_chk("drain_pre", 4'd1, 1'b0);
    cyc(2'b10, 3'd0, 3'd7, 2'b10, "drain7");
    idle_chk("exhausted", 4'd0, 1'b1);
    cyc(2'b01, 3'd4, 3'd0, 2'b01, "reread4");
    idle_chk("reread_after", 4'd0, 1'b1);

    // Lock mid-stream with a response in flight, then abort.
    load(1'b1, "load_lock");
    cyc(2'b01, 3'd2, 3'd0, 2'b01, "inflight");
    bus.loader_busy = 1'b1;
    bus.core_enable = 1'b0;
    cyc(2'b01, 3'd3, 3'd0, 2'b00, "lockdrop");
    mburn = '1;
    @(negedge clk);
    chk("lock_left", 32'(bus.words_left), 32'd0);
    @(posedge clk); #1;
    bus.loader_busy = 1'b0;
    cyc(2'b11, 3'd0, 3'd1, 2'b00, "abort0");
    cyc(2'b11, 3'd0, 3'd1, 2'b00, "abort1");
    cyc(2'b11, 3'd0, 3'd1, 2'b00, "abort2");
    @(negedge clk);
    chk("abort_left", 32'(bus.words_left), 32'd0);
    @(posedge clk); #1;

    // Reset during a grant cycle kills the response and the arbiter history.
    load(1'b0, "load_rst");
    bus.req_valid = 2'b01;
    bus.req_idx0  = 3'd1;
    @(negedge clk);
    chk("rst_gnt", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b0;
    chk_reset("rst_mid0");
    chk_reset("rst_mid1");
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.core_enable = 1'b0;
    load(1'b0, "load_post");
    cyc(2'b11, 3'd6, 3'd7, 2'b01, "post_tie");
    idle_chk("post_after", 4'd8, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
